// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch FSM encoding, reset PC and instruction size
package pipeline_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetchState_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/boot_timer.sv
// rtl/boot_timer.sv - counts idle cycles after reset release; done holds once reached
module boot_timer #(
    parameter int BOOT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic done
);

    localparam logic [3:0] LAST = 4'(BOOT_CYCLES - 1);

    logic [3:0] count;

    // done is asserted during the final idle cycle so the FSM leaves BOOT on that edge
    assign done = (count >= LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (en && !done) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing and Fetch/Decode/Execute stall/flush control
module fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BOOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        LoadUseHazard,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] PCF,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE
);

    fetchState_t state, nextState;
    logic [31:0] pcReg, nextPc;
    logic [31:0] pendingPc, nextPending;
    logic        bootDone;

    boot_timer #(.BOOT_CYCLES(BOOT_CYCLES)) bootTimer (
        .clk  (clk),
        .rst  (rst),
        .en   (state == BOOT),
        .done (bootDone)
    );

    assign PCF = pcReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pcReg     <= RESET_PC;
            pendingPc <= 32'h0;
        end else begin
            state     <= nextState;
            pcReg     <= nextPc;
            pendingPc <= nextPending;
        end
    end

    always_comb begin
        nextState   = state;
        nextPc      = pcReg;
        nextPending = pendingPc;
        imem_req    = 1'b1;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        unique case (state)
            BOOT: begin
                imem_req = 1'b0;
                StallF   = 1'b1;
                FlushD   = 1'b1;
                FlushE   = 1'b1;
                if (bootDone) nextState = FETCH;
            end
            FETCH: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (imem_ack) begin
                        nextPc = PCTargetE;
                    end else begin
                        StallF      = 1'b1;
                        nextPending = PCTargetE;
                        nextState   = DRAIN;
                    end
                end else if (LoadUseHazard) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (imem_ack) begin
                    nextPc = pcReg + INSTR_BYTES;
                end else begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                end
            end
            DRAIN: begin
                // the in-flight fetch belongs to the squashed path, so Decode always gets a bubble
                FlushD = 1'b1;
                FlushE = PCSrcE | LoadUseHazard;
                StallF = ~imem_ack;
                if (PCSrcE) nextPending = PCTargetE;
                if (imem_ack) begin
                    nextPc    = PCSrcE ? PCTargetE : pendingPc;
                    nextState = FETCH;
                end
            end
            default: begin
                nextState = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with directed and random stimulus
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          BOOT_N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        LoadUseHazard = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] PCF;
    logic        StallF, StallD, FlushD, FlushE;

    fetch_ctrl #(.RESET_PC(RST_PC), .BOOT_CYCLES(BOOT_N)) dut (
        .clk           (clk),
        .rst           (rst),
        .PCSrcE        (PCSrcE),
        .PCTargetE     (PCTargetE),
        .LoadUseHazard (LoadUseHazard),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .PCF           (PCF),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .FlushE        (FlushE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        req, stallF, stallD, flushD, flushE;
        logic        chkStallF;
    } expect_t;

    expect_t expQ[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model: cycles of boot left, whether a squashed fetch is still outstanding, redirect target
    int          bootLeft;
    logic [31:0] modelPc;
    logic        draining;
    logic [31:0] pending;

    function automatic void modelReset();
        bootLeft = BOOT_N;
        modelPc  = RST_PC;
        draining = 1'b0;
        pending  = 32'h0;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // drive one cycle of inputs at a falling edge, record what the DUT must show, advance the model
    task automatic cycle(input logic src, input logic [31:0] tgt, input logic luh, input logic ack);
        expect_t e;
        PCSrcE = src; PCTargetE = tgt; LoadUseHazard = luh; imem_ack = ack;
        e.pc = modelPc; e.chkStallF = 1'b1;
        e.stallD = 1'b0;
        if (bootLeft > 0) begin
            e.req = 0; e.stallF = 1; e.flushD = 1; e.flushE = 1;
            bootLeft--;
        end else if (!draining) begin
            e.req = 1;
            if (src) begin
                e.flushD = 1; e.flushE = 1; e.stallF = !ack;
                if (ack) modelPc = tgt;
                else begin pending = tgt; draining = 1; end
            end else if (luh) begin
                e.stallF = 1; e.stallD = 1; e.flushD = 0; e.flushE = 1;
            end else if (ack) begin
                e.stallF = 0; e.flushD = 0; e.flushE = 0;
                modelPc = modelPc + 32'd4;
            end else begin
                e.stallF = 1; e.flushD = 1; e.flushE = 0;
            end
        end else begin
            e.req = 1; e.flushD = 1; e.flushE = src | luh;
            e.stallF = 0; e.chkStallF = 0;
            if (src) pending = tgt;
            if (ack) begin modelPc = pending; draining = 0; end
        end
        expQ.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check1("PCF", PCF, e.pc);
                check1("imem_req", 32'(imem_req), 32'(e.req));
                check1("StallD", 32'(StallD), 32'(e.stallD));
                check1("FlushD", 32'(FlushD), 32'(e.flushD));
                check1("FlushE", 32'(FlushE), 32'(e.flushE));
                if (e.chkStallF) check1("StallF", 32'(StallF), 32'(e.stallF));
            end
        end
    end

    initial begin : stim
        modelReset();
        repeat (20) @(negedge clk);
        #3;
        check1("reset_PCF", PCF, RST_PC);
        check1("reset_req", 32'(imem_req), 32'd0);
        check1("reset_StallF", 32'(StallF), 32'd1);
        check1("reset_FlushE", 32'(FlushE), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // boot with ack tied high, then 0,4,8,C
        repeat (BOOT_N + 4) cycle(0, 0, 0, 1);
        cycle(1, 32'h40, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        // withheld ack with redirect, single then double redirect in DRAIN
        cycle(1, 32'h80, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(1, 32'h100, 0, 0);
        cycle(1, 32'h80, 0, 0);
        cycle(1, 32'hC0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        // 32-bit wrap
        cycle(1, 32'hFFFF_FFFC, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 6);
        end

        // enter DRAIN then pulse reset asynchronously mid-cycle
        cycle(0, 0, 0, 1);
        cycle(1, 32'h200, 0, 0);
        #4;
        rst = 1'b0;
        #1;
        check1("rst_drain_PCF", PCF, RST_PC);
        check1("rst_drain_req", 32'(imem_req), 32'd0);
        check1("rst_drain_FlushD", 32'(FlushD), 32'd1);
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        modelReset();
        rst = 1'b1;
        repeat (BOOT_N + 3) cycle(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        #4;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
